conv_pool_sched: RTL and testbench

Frame-level sequencer for the stride-2 3x3-conv / 2x2-avg-pool datapath. On a start command it walks a configurable image, one 4x4 window per cycle, and drives the datapath's `input_re`/`input_addr` read port. It tags each issued window through a delay line matched to the datapath latency, producing aligned `output_we`/`output_addr` for the result memory. It reports busy/done/err to the host.

---
 rtl/conv_pool_sched.sv | 140 ++++++++++++++
 tb/tb_conv_pool_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_sched.sv
// rtl/conv_pool_sched.sv - window issue sequencer for the stride-2 conv/pool datapath
// Walks output tiles, issues 4x4 window reads and tags results through a PIPE_LAT delay line.
module conv_pool_sched #(
  parameter int PIPE_LAT = 4,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic [7:0]        cfg_img_w,
  input  logic [7:0]        cfg_img_h,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              input_re,
  output logic [ADDR_W-1:0] input_addr,
  output logic              output_we,
  output logic [ADDR_W-1:0] output_addr
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t            state;
  logic [7:0]        w_r, ow_r, oh_r, col, row;
  logic [ADDR_W-1:0] addr_r, row_base, oaddr_r;
  logic [PIPE_LAT-1:0] dl_v;
  logic [ADDR_W-1:0] dl_a [PIPE_LAT];

  logic              is_idle, cfg_ok, launch, kill, issue, last_col, last_row;
  logic [7:0]        w_src, ow_src, oh_src, col_src, row_src;
  logic [ADDR_W-1:0] a_src, rb_src, o_src, row_step;

  // In IDLE the first window is issued straight from the cfg inputs, so every
  // counter source is muxed between the live config and the running registers.
  always_comb begin
    is_idle  = (state == IDLE);
    cfg_ok   = !cfg_img_w[0] && !cfg_img_h[0] && (cfg_img_w >= 8'd4) && (cfg_img_h >= 8'd4);
    launch   = is_idle && start && cfg_ok;
    kill     = abort && !is_idle;
    issue    = launch || ((state == ISSUE) && !pause && !abort);
    w_src    = is_idle ? cfg_img_w : w_r;
    ow_src   = is_idle ? ((cfg_img_w - 8'd2) >> 1) : ow_r;
    oh_src   = is_idle ? ((cfg_img_h - 8'd2) >> 1) : oh_r;
    col_src  = is_idle ? 8'd0 : col;
    row_src  = is_idle ? 8'd0 : row;
    a_src    = is_idle ? cfg_in_base : addr_r;
    rb_src   = is_idle ? cfg_in_base : row_base;
    o_src    = is_idle ? cfg_out_base : oaddr_r;
    last_col = (col_src == ow_src - 8'd1);
    last_row = (row_src == oh_src - 8'd1);
    row_step = rb_src + (ADDR_W'(w_src) << 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      w_r         <= '0;
      ow_r        <= '0;
      oh_r        <= '0;
      col         <= '0;
      row         <= '0;
      addr_r      <= '0;
      row_base    <= '0;
      oaddr_r     <= '0;
      dl_v        <= '0;
      for (int i = 0; i < PIPE_LAT; i++) dl_a[i] <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      input_re    <= 1'b0;
      input_addr  <= '0;
      output_we   <= 1'b0;
      output_addr <= '0;
    end else begin
      err      <= is_idle && start && !cfg_ok;
      done     <= 1'b0;
      input_re <= issue;

      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
      end
      dl_v[0]   <= issue;
      dl_a[0]   <= o_src;
      output_we <= dl_v[PIPE_LAT-1];
      if (dl_v[PIPE_LAT-1] && !kill) output_addr <= dl_a[PIPE_LAT-1];

      if (launch) begin
        w_r  <= cfg_img_w;
        ow_r <= ow_src;
        oh_r <= oh_src;
        busy <= 1'b1;
      end

      if (issue) begin
        input_addr <= a_src;
        oaddr_r    <= o_src + ADDR_W'(1);
        if (last_col) begin
          col      <= 8'd0;
          row      <= row_src + 8'd1;
          row_base <= row_step;
          addr_r   <= row_step;
        end else begin
          col      <= col_src + 8'd1;
          row      <= row_src;
          row_base <= rb_src;
          addr_r   <= a_src + ADDR_W'(2);
        end
        state <= (last_col && last_row) ? DRAIN : ISSUE;
      end

      case (state)
        DRAIN: if (dl_v == '0) begin
          done  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: ;
      endcase

      // Abort discards everything in flight; nothing already issued is written back.
      if (kill) begin
        state     <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
        input_re  <= 1'b0;
        output_we <= 1'b0;
        dl_v      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_conv_pool_sched.sv
// tb/tb_conv_pool_sched.sv - self-checking bench for conv_pool_sched
// Frame traces are predicted from tile arithmetic and compared every cycle.
module tb_conv_pool_sched;

  localparam int L    = 4;
  localparam int MAXC = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, pause, abort;
  logic [7:0]  cfg_img_w, cfg_img_h;
  logic [15:0] cfg_in_base, cfg_out_base;
  logic        busy, done, err, input_re, output_we;
  logic [15:0] input_addr, output_addr;

  int checks = 0;
  int failures = 0;
  int cur_n = 0;
  logic [15:0] m_ia = 16'h0;
  logic [15:0] m_oa = 16'h0;

  conv_pool_sched #(.PIPE_LAT(L), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
    .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
    .busy(busy), .done(done), .err(err),
    .input_re(input_re), .input_addr(input_addr),
    .output_we(output_we), .output_addr(output_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cur_n, act, exp);
    end
  endtask

  task automatic run_frame(input int w, input int h, input logic [15:0] inb, input logic [15:0] outb,
                           input int pz_pct, input int p_from, input int p_len,
                           input int abort_at, input int mid_start,
                           output int n_re, output int busy_len,
                           output logic [15:0] first_ia, output logic [15:0] last_ia,
                           output int err_seen);
    bit pz [MAXC];
    bit e_re [MAXC];
    bit e_we [MAXC];
    bit e_busy [MAXC];
    bit e_done [MAXC];
    bit e_err [MAXC];
    logic [15:0] r_ia [MAXC];
    logic [15:0] r_oa [MAXC];
    logic [15:0] e_ia [MAXC];
    logic [15:0] e_oa [MAXC];
    int ow, oh, tt, k, last, dn, ncyc;
    bit legal, ms_ok;
    logic [15:0] cia, coa;

    for (int n = 0; n < MAXC; n++) begin
      pz[n] = ((n >= p_from) && (n < p_from + p_len)) ||
              ((n > 0) && (n < 150) && ($urandom_range(99) < pz_pct));
      e_re[n] = 0; e_we[n] = 0; e_busy[n] = 0; e_done[n] = 0; e_err[n] = 0;
      r_ia[n] = '0; r_oa[n] = '0; e_ia[n] = '0; e_oa[n] = '0;
    end
    legal = (w % 2 == 0) && (h % 2 == 0) && (w >= 4) && (h >= 4);
    dn = 0;
    if (!legal) begin
      e_err[1] = 1;
      ncyc = 4;
    end else begin
      ow = (w - 2) / 2;
      oh = (h - 2) / 2;
      tt = ow * oh;
      k = 0;
      last = 1;
      for (int n = 1; n < MAXC - L - 8 && k < tt; n++) begin
        if (n == 1 || !pz[n-1]) begin
          e_re[n] = 1;
          r_ia[n] = 16'(int'(inb) + 2 * (k / ow) * w + 2 * (k % ow));
          e_we[n+L] = 1;
          r_oa[n+L] = 16'(int'(outb) + k);
          last = n;
          k++;
        end
      end
      dn = last + L + 1;
      e_done[dn] = 1;
      for (int n = 1; n <= dn; n++) e_busy[n] = 1;
      ncyc = dn + 2;
      if (abort_at >= 1 && abort_at < ncyc) begin
        for (int n = abort_at + 1; n < MAXC; n++) begin
          e_re[n] = 0; e_we[n] = 0; e_done[n] = 0; e_busy[n] = 0;
        end
        ncyc = abort_at + 4;
      end
    end
    ms_ok = legal && (mid_start >= 1) && (mid_start <= dn) && (abort_at < 1 || mid_start <= abort_at);
    cia = m_ia;
    coa = m_oa;
    for (int n = 1; n <= ncyc; n++) begin
      if (e_re[n]) cia = r_ia[n];
      if (e_we[n]) coa = r_oa[n];
      e_ia[n] = cia;
      e_oa[n] = coa;
    end

    cfg_img_w = 8'(w);
    cfg_img_h = 8'(h);
    cfg_in_base = inb;
    cfg_out_base = outb;
    start = 1'b1;
    abort = (abort_at == 0);
    pause = 1'b0;
    step();
    start = 1'b0;
    abort = 1'b0;
    n_re = 0; busy_len = 0; first_ia = '0; last_ia = '0; err_seen = 0;
    for (int n = 1; n <= ncyc; n++) begin
      cur_n = n;
      chk("input_re", 32'(input_re), 32'(e_re[n]));
      chk("input_addr", 32'(input_addr), 32'(e_ia[n]));
      chk("output_we", 32'(output_we), 32'(e_we[n]));
      chk("output_addr", 32'(output_addr), 32'(e_oa[n]));
      chk("busy", 32'(busy), 32'(e_busy[n]));
      chk("done", 32'(done), 32'(e_done[n]));
      chk("err", 32'(err), 32'(e_err[n]));
      if (input_re === 1'b1) begin
        n_re++;
        if (n_re == 1) first_ia = input_addr;
        last_ia = input_addr;
      end
      if (busy === 1'b1) busy_len++;
      if (err === 1'b1) err_seen++;
      pause = pz[n];
      abort = (n == abort_at);
      start = ms_ok && (n == mid_start);
      if (start) begin
        cfg_img_w = 8'($urandom_range(4, 20) * 2);
        cfg_img_h = 8'($urandom_range(2, 10) * 2);
        cfg_in_base = 16'($urandom);
        cfg_out_base = 16'($urandom);
      end
      step();
    end
    pause = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    m_ia = cia;
    m_oa = coa;
  endtask

  typedef struct {
    int          w;
    int          h;
    logic [15:0] inb;
    logic [15:0] outb;
    int          exp_err;
    int          exp_n;
    int          exp_busy;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n_re, busy_len, err_seen;
    logic [15:0] fa, la;

    vecs[0] = '{4,  4,  16'h0100, 16'h2000, 0, 1,  6,  16'h0100, 16'h0100};
    vecs[1] = '{8,  6,  16'h0000, 16'h0000, 0, 6,  11, 16'h0000, 16'h0014};
    vecs[2] = '{5,  4,  16'h0000, 16'h0000, 1, 0,  0,  16'h0000, 16'h0000};
    vecs[3] = '{4,  2,  16'h0000, 16'h0000, 1, 0,  0,  16'h0000, 16'h0000};
    vecs[4] = '{6,  8,  16'h0010, 16'h0100, 0, 6,  11, 16'h0010, 16'h002A};
    vecs[5] = '{10, 10, 16'hFFF0, 16'hFFFE, 0, 16, 21, 16'hFFF0, 16'h0032};
    vecs[6] = '{3,  4,  16'h0000, 16'h0000, 1, 0,  0,  16'h0000, 16'h0000};
    vecs[7] = '{4,  5,  16'h0000, 16'h0000, 1, 0,  0,  16'h0000, 16'h0000};
    vecs[8] = '{16, 4,  16'h1234, 16'h0040, 0, 7,  12, 16'h1234, 16'h1240};

    rst = 1'b0;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    cfg_img_w = '0; cfg_img_h = '0; cfg_in_base = '0; cfg_out_base = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_input_re", 32'(input_re), 32'd0);
    chk("rst_input_addr", 32'(input_addr), 32'd0);
    chk("rst_output_we", 32'(output_we), 32'd0);
    chk("rst_output_addr", 32'(output_addr), 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].w, vecs[i].h, vecs[i].inb, vecs[i].outb, 0, 0, 0, -1, 0,
                n_re, busy_len, fa, la, err_seen);
      chk("tbl_err", 32'(err_seen), 32'(vecs[i].exp_err));
      chk("tbl_windows", 32'(n_re), 32'(vecs[i].exp_n));
      chk("tbl_busy_len", 32'(busy_len), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_err == 0) begin
        chk("tbl_first_addr", 32'(fa), 32'(vecs[i].exp_first));
        chk("tbl_last_addr", 32'(la), 32'(vecs[i].exp_last));
      end
    end

    run_frame(8, 6, 16'h0000, 16'h0000, 0, 2, 2, -1, 0, n_re, busy_len, fa, la, err_seen);
    chk("pause_windows", 32'(n_re), 32'd6);
    chk("pause_busy_len", 32'(busy_len), 32'd13);

    run_frame(8, 6, 16'h0000, 16'h0000, 0, 0, 0, 3, 0, n_re, busy_len, fa, la, err_seen);
    chk("abort_windows", 32'(n_re), 32'd3);
    chk("abort_busy_len", 32'(busy_len), 32'd3);

    run_frame(8, 6, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, n_re, busy_len, fa, la, err_seen);
    chk("start_abort_idle_windows", 32'(n_re), 32'd6);

    run_frame(8, 6, 16'h0040, 16'h0080, 0, 0, 0, -1, 3, n_re, busy_len, fa, la, err_seen);
    chk("midstart_windows", 32'(n_re), 32'd6);
    chk("midstart_busy_len", 32'(busy_len), 32'd11);

    cfg_img_w = 8'd8; cfg_img_h = 8'd6; cfg_in_base = 16'h0300; cfg_out_base = 16'h0400;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    cur_n = 8;
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_input_re", 32'(input_re), 32'd0);
    chk("arst_input_addr", 32'(input_addr), 32'd0);
    chk("arst_output_we", 32'(output_we), 32'd0);
    chk("arst_output_addr", 32'(output_addr), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    step();
    step();
    rst = 1'b1;
    m_ia = 16'h0;
    m_oa = 16'h0;
    for (int n = 0; n < 6; n++) begin
      step();
      cur_n = n;
      chk("post_rst_idle", 32'({busy, input_re, output_we, done}), 32'd0);
    end
    run_frame(8, 6, 16'h0300, 16'h0400, 0, 0, 0, -1, 0, n_re, busy_len, fa, la, err_seen);
    chk("post_rst_windows", 32'(n_re), 32'd6);

    for (int r = 0; r < 24; r++) begin
      int rw, rh, ab, ms;
      rw = (r % 6 == 5) ? int'($urandom_range(3, 9)) : int'($urandom_range(2, 8)) * 2;
      rh = int'($urandom_range(2, 8)) * 2;
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(1, 40)) : -1;
      ms = ($urandom_range(3) == 0) ? int'($urandom_range(1, 30)) : 0;
      run_frame(rw, rh, 16'($urandom), 16'($urandom), 25, 0, 0, ab, ms,
                n_re, busy_len, fa, la, err_seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
